// File: rtl/os_lane_scheduler.sv
// os_lane_scheduler: funnels per-lane ordered sets into one shared os_checker.
// Each lane owns a one-entry buffer. A round-robin arbiter moves one buffered
// set per cycle into a valid/ready output register. A change of LTSSM
// substate flushes every buffer and pulses flush for one cycle.

module os_lane_scheduler #(
    parameter int LANES    = 4,
    parameter int OS_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  substate,
    input  logic [LANES*OS_WIDTH-1:0]   lane_os,
    input  logic [LANES-1:0]            lane_valid,
    input  logic                        os_ready,
    output logic                        os_valid,
    output logic [OS_WIDTH-1:0]         os_out,
    output logic [$clog2(LANES)-1:0]    os_lane,
    output logic [LANES-1:0]            overflow,
    output logic                        flush,
    output logic                        busy
);

    localparam int LW = $clog2(LANES);

    // Round-robin pick: the first full lane after 'last' wins, wrapping
    // LANES-1 -> 0. Returns {found, index}.
    function automatic logic [LW:0] rr_pick(
        input logic [LANES-1:0] full,
        input logic [LW-1:0]    last
    );
        logic          found;
        logic [LW-1:0] sel;
        logic [LW-1:0] cand;
        int            pos;
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        pos   = 0;
        for (int off = 1; off <= LANES; off++) begin
            pos  = (int'(last) + off) % LANES;
            cand = LW'(pos);
            if (!found && full[cand]) begin
                found = 1'b1;
                sel   = cand;
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

    // State registers and their next-state values
    logic [3:0]                         substate_q;
    logic [LANES-1:0]                   buf_full_q,  buf_full_d;
    logic [LANES-1:0][OS_WIDTH-1:0]     buf_data_q,  buf_data_d;
    logic [LANES-1:0]                   overflow_q,  overflow_d;
    logic [LW-1:0]                      last_grant_q, last_grant_d;
    logic                               os_valid_q,  os_valid_d;
    logic [OS_WIDTH-1:0]                os_out_q,    os_out_d;
    logic [LW-1:0]                      os_lane_q,   os_lane_d;
    logic                               flush_q,     flush_d;

    // Combinational helpers
    logic                               load_en_s;
    logic                               sub_change_s;
    logic                               grant_valid_s;
    logic [LW-1:0]                      grant_idx_s;
    logic [LANES-1:0]                   drain_s;

    // Arbitration: decide whether the output register reloads and which lane drains
    always_comb begin
        load_en_s                    = (!os_valid_q) || os_ready;
        sub_change_s                 = (substate != substate_q);
        {grant_valid_s, grant_idx_s} = rr_pick(buf_full_q, last_grant_q);
        drain_s                      = '0;
        for (int i = 0; i < LANES; i++) begin
            drain_s[i] = load_en_s && grant_valid_s && (grant_idx_s == LW'(i));
        end
    end

    // Next-state: a substate change wins over capture, grant and handshake
    always_comb begin
        buf_full_d   = buf_full_q;
        buf_data_d   = buf_data_q;
        overflow_d   = overflow_q;
        last_grant_d = last_grant_q;
        os_valid_d   = os_valid_q;
        os_out_d     = os_out_q;
        os_lane_d    = os_lane_q;
        flush_d      = 1'b0;

        if (sub_change_s) begin
            // Inputs arriving at the flushing edge are discarded silently.
            buf_full_d   = '0;
            overflow_d   = '0;
            os_valid_d   = 1'b0;
            last_grant_d = LW'(LANES - 1);
            flush_d      = 1'b1;
        end else begin
            // Output register: reload when empty or when the checker takes it.
            if (load_en_s) begin
                if (grant_valid_s) begin
                    os_valid_d   = 1'b1;
                    os_out_d     = buf_data_q[grant_idx_s];
                    os_lane_d    = grant_idx_s;
                    last_grant_d = grant_idx_s;
                end else begin
                    os_valid_d   = 1'b0;
                end
            end else begin
                os_valid_d = os_valid_q;
            end

            // Lane buffers: a buffer drained this edge may be refilled this edge.
            for (int i = 0; i < LANES; i++) begin
                if (lane_valid[i]) begin
                    if (!buf_full_q[i] || drain_s[i]) begin
                        buf_full_d[i] = 1'b1;
                        buf_data_d[i] = lane_os[i*OS_WIDTH +: OS_WIDTH];
                    end else begin
                        overflow_d[i] = 1'b1;
                    end
                end else if (drain_s[i]) begin
                    buf_full_d[i] = 1'b0;
                end else begin
                    buf_full_d[i] = buf_full_q[i];
                end
            end
        end
    end

    // State register with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            substate_q   <= 4'd0;
            buf_full_q   <= '0;
            buf_data_q   <= '0;
            overflow_q   <= '0;
            last_grant_q <= LW'(LANES - 1);
            os_valid_q   <= 1'b0;
            os_out_q     <= '0;
            os_lane_q    <= '0;
            flush_q      <= 1'b0;
        end else begin
            substate_q   <= substate;
            buf_full_q   <= buf_full_d;
            buf_data_q   <= buf_data_d;
            overflow_q   <= overflow_d;
            last_grant_q <= last_grant_d;
            os_valid_q   <= os_valid_d;
            os_out_q     <= os_out_d;
            os_lane_q    <= os_lane_d;
            flush_q      <= flush_d;
        end
    end

    assign os_valid = os_valid_q;
    assign os_out   = os_out_q;
    assign os_lane  = os_lane_q;
    assign overflow = overflow_q;
    assign flush    = flush_q;
    // busy reflects pending work in the same cycle, so it is not re-registered.
    assign busy     = (|buf_full_q) | os_valid_q;

    os_lane_scheduler_chk #(
        .OS_WIDTH (OS_WIDTH),
        .LW       (LW)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .substate   (substate),
        .substate_q (substate_q),
        .os_valid   (os_valid_q),
        .os_ready   (os_ready),
        .os_out     (os_out_q),
        .os_lane    (os_lane_q),
        .flush      (flush_q)
    );

endmodule

// os_lane_scheduler_chk: protocol properties of the scheduler output side.
module os_lane_scheduler_chk #(
    parameter int OS_WIDTH = 128,
    parameter int LW       = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          substate,
    input  logic [3:0]          substate_q,
    input  logic                os_valid,
    input  logic                os_ready,
    input  logic [OS_WIDTH-1:0] os_out,
    input  logic [LW-1:0]       os_lane,
    input  logic                flush
);

    // A stalled set must stay put until the checker accepts it.
    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (os_valid && !os_ready && (substate == substate_q))
        |=> (os_valid && $stable(os_out) && $stable(os_lane)));

    // A substate change is always followed by a one-cycle flush pulse.
    a_flush_pulse: assert property (@(posedge clk) disable iff (reset)
        (substate != substate_q) |=> (flush && !os_valid));

endmodule
